nem_ohmux_sel_ctrl: RTL and testbench
=====================================

Name: nem_ohmux_sel_ctrl

Overview:
- Sequential select driver for the NEM one-hot inverting muxes (4-input, 8-bit bank). It produces the one-hot S[N_IN-1:0] lines that those muxes consume.
- Accepts a binary select request over a valid/ready handshake.
- Enforces break-before-make relay sequencing: all selects are released, the controller waits T_BREAK, then asserts the target select and waits T_MAKE.
- Reports when the mux output ZN is settled and valid.

Parameters:
- N_IN, 4, number of mux inputs (width of S); must be 2 or greater.
- SEL_W, $clog2(N_IN), width of the binary select (derived; do not override).
- CNT_W, 8, width of the dwell counter.
- T_BREAK, 4, cycles that S is held all-zero before a make; range 1..2^CNT_W.
- T_MAKE, 8, cycles the new select must settle before done; range 1..2^CNT_W.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  a select request is present.
- req_ready  out  1  the controller can accept a request (high only in IDLE).
- req_sel  in  SEL_W  binary index of the input to select.
- req_off  in  1  deselect all inputs; req_sel is ignored.
- S  out  N_IN  one-hot select lines to the mux; all-zero or exactly one bit set.
- cur_sel  out  SEL_W  index of the last completed select.
- sel_valid  out  1  S is non-zero and settled, so mux output ZN is valid.
- busy  out  1  a BREAK or MAKE sequence is in progress.
- done  out  1  single-cycle pulse when a request completes.

Behaviour:
- Reset values: state=IDLE, S=0, cur_sel=0, sel_valid=0, busy=0, done=0, req_ready=1.
- All outputs are registered except req_ready, which equals (state==IDLE).
- States are IDLE, BREAK and MAKE. A request is accepted on an edge where req_valid && req_ready.
- IDLE, no-op accept: if the request is not off, req_sel==cur_sel and sel_valid==1, S is unchanged. Next cycle done=1 and the state stays IDLE.
- IDLE, other accepts: on the next edge S=0, sel_valid=0, busy=1, cnt=T_BREAK-1, target latched, state=BREAK.
- This applies even when S is already 0, so relay release time is always honoured.
- Out-of-range select: req_sel>=N_IN (possible when N_IN is not a power of 2) is treated as req_off.
- BREAK: S stays 0. If cnt!=0, decrement cnt. If cnt==0:
  - off target: state=IDLE, busy=0, done=1, sel_valid=0, cur_sel unchanged.
  - otherwise: S=onehot(target), cur_sel=target, cnt=T_MAKE-1, state=MAKE.
- MAKE: S is held. If cnt!=0, decrement cnt. If cnt==0: state=IDLE, busy=0, sel_valid=1, done=1.
- Timing: accept edge k. S is 0 for cycles k+1..k+T_BREAK. S is one-hot from k+1+T_BREAK. done and sel_valid go high in cycle k+1+T_BREAK+T_MAKE.
- done is a pulse. It clears on the next edge unless another no-op accept happens in that cycle; back-to-back no-ops give consecutive done cycles.
- Requests arriving while busy are not accepted (req_ready=0). The requester must hold req_valid, req_sel and req_off stable until accepted.
- S never has more than one bit set. There is never a cycle where the old and new select bits are both high.
- Reset mid-sequence takes priority over everything: the next edge forces the reset values, so S=0 immediately and the dwell is abandoned.
- Simultaneous rst and req_valid: the request is dropped.

Decomposition:
- Shared package nem_ohmux_pkg:
  - state enum (IDLE, BREAK, MAKE).
  - onehot function (index -> N_IN-bit vector).
  - default timing constants NEM_T_BREAK and NEM_T_MAKE.
- One sub-module, nem_dwell_timer: loadable down-counter with load, load value, enable and a zero flag. It is reused for both the BREAK and MAKE dwells.

Test Plan:
- Defaults, post-reset: req_sel=2, valid=1 for 1 cycle, accepted at edge 0 -> S=0000 for cycles 1-4, S=0100 from cycle 5, cur_sel=2, done and sel_valid high at cycle 13, req_ready low in cycles 1-12.
- Switch 2->0 after a settled select -> S drops to 0000 for exactly 4 cycles, then 0001; the S bus is never 0101; done exactly 12 cycles after accept.
- Repeat req_sel=2 while settled -> no S glitch, done at the next cycle, busy stays 0; req_off=1 -> S=0000, done after 4 cycles, sel_valid=0.
- Assert rst during MAKE (cycle 7 of a sequence) -> next cycle S=0000, busy=0, done=0, req_ready=1; a fresh request then completes with full 4+8 timing.
- Hold req_valid with req_sel=3 while busy -> it is not accepted until IDLE, then accepted the first IDLE cycle; T_BREAK=1, T_MAKE=1 corner gives done 2 cycles after accept.
- N_IN=3 with req_sel=3 -> treated as off: S=000, done after T_BREAK; assertion checks throughout confirm S is always all-zero or exactly one bit set.

Source files
------------

// File: rtl/nem_ohmux_pkg.sv
// Shared types, timing defaults and helpers for the NEM one-hot mux select path.
package nem_ohmux_pkg;

    // Widest mux bank the onehot helper supports.
    localparam int unsigned NEM_MAX_N_IN = 32;
    localparam int unsigned NEM_IDX_W    = 5;

    // Default relay dwell times in clock cycles.
    localparam int unsigned NEM_T_BREAK = 4;
    localparam int unsigned NEM_T_MAKE  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BREAK = 2'd1,
        ST_MAKE  = 2'd2
    } state_t;

    // Binary index to one-hot vector; callers truncate to their bank width.
    function automatic logic [NEM_MAX_N_IN-1:0] onehot(input logic [NEM_IDX_W-1:0] idx);
        logic [NEM_MAX_N_IN-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/nem_ohmux_sel_ctrl_dwell_timer.sv
// Loadable down-counter shared by the BREAK and MAKE relay dwells.
module nem_dwell_timer
    import nem_ohmux_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_zero_c
);

    logic [CNT_W-1:0] r_cnt;

    // Load wins over decrement; the count parks at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/nem_ohmux_sel_ctrl.sv
// Break-before-make select sequencer for the NEM one-hot inverting mux bank.
module nem_ohmux_sel_ctrl
    import nem_ohmux_pkg::*;
#(
    parameter int unsigned N_IN    = 4,
    parameter int unsigned SEL_W   = $clog2(N_IN),
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned T_BREAK = NEM_T_BREAK,
    parameter int unsigned T_MAKE  = NEM_T_MAKE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] req_sel,
    input  logic             req_off,
    output logic [N_IN-1:0]  S,
    output logic [SEL_W-1:0] cur_sel,
    output logic             sel_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned      SEL_W1      = SEL_W + 1;
    localparam logic [CNT_W-1:0] LP_BREAK_LD = CNT_W'(T_BREAK - 1);
    localparam logic [CNT_W-1:0] LP_MAKE_LD  = CNT_W'(T_MAKE - 1);

    state_t           r_state, w_state_nxt;
    logic [N_IN-1:0]  r_s, w_s_nxt;
    logic [SEL_W-1:0] r_cur_sel, w_cur_sel_nxt;
    logic [SEL_W-1:0] r_target, w_target_nxt;
    logic             r_target_off, w_target_off_nxt;
    logic             r_sel_valid, w_sel_valid_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;

    logic             w_req_off;
    logic             w_noop;
    logic             w_tmr_load;
    logic [CNT_W-1:0] w_tmr_load_val;
    logic             w_tmr_en;
    logic             w_tmr_zero;

    // An index past the last input can only mean "nothing selected".
    assign w_req_off = req_off || ({1'b0, req_sel} >= SEL_W1'(N_IN));
    assign w_noop    = !w_req_off && (req_sel == r_cur_sel) && r_sel_valid;
    assign req_ready = (r_state == ST_IDLE);

    nem_dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_load_val),
        .i_en       (w_tmr_en),
        .o_zero_c   (w_tmr_zero)
    );

    // Next-state and next-output decode for the IDLE/BREAK/MAKE sequence.
    always_comb begin
        w_state_nxt      = r_state;
        w_s_nxt          = r_s;
        w_cur_sel_nxt    = r_cur_sel;
        w_target_nxt     = r_target;
        w_target_off_nxt = r_target_off;
        w_sel_valid_nxt  = r_sel_valid;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_tmr_load       = 1'b0;
        w_tmr_load_val   = LP_BREAK_LD;
        w_tmr_en         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_noop) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        // Release every relay first, even if S is already zero.
                        w_s_nxt          = '0;
                        w_sel_valid_nxt  = 1'b0;
                        w_busy_nxt       = 1'b1;
                        w_tmr_load       = 1'b1;
                        w_tmr_load_val   = LP_BREAK_LD;
                        w_target_nxt     = req_sel;
                        w_target_off_nxt = w_req_off;
                        w_state_nxt      = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                w_tmr_en = 1'b1;
                if (w_tmr_zero) begin
                    if (r_target_off) begin
                        w_state_nxt     = ST_IDLE;
                        w_busy_nxt      = 1'b0;
                        w_done_nxt      = 1'b1;
                        w_sel_valid_nxt = 1'b0;
                    end else begin
                        w_s_nxt        = N_IN'(onehot(NEM_IDX_W'(r_target)));
                        w_cur_sel_nxt  = r_target;
                        w_tmr_load     = 1'b1;
                        w_tmr_load_val = LP_MAKE_LD;
                        w_state_nxt    = ST_MAKE;
                    end
                end
            end
            ST_MAKE: begin
                w_tmr_en = 1'b1;
                if (w_tmr_zero) begin
                    w_state_nxt     = ST_IDLE;
                    w_busy_nxt      = 1'b0;
                    w_sel_valid_nxt = 1'b1;
                    w_done_nxt      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any dwell in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_s          <= '0;
            r_cur_sel    <= '0;
            r_target     <= '0;
            r_target_off <= 1'b0;
            r_sel_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_s          <= w_s_nxt;
            r_cur_sel    <= w_cur_sel_nxt;
            r_target     <= w_target_nxt;
            r_target_off <= w_target_off_nxt;
            r_sel_valid  <= w_sel_valid_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign S         = r_s;
    assign cur_sel   = r_cur_sel;
    assign sel_valid = r_sel_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_nem_ohmux_sel_ctrl.sv
// Scoreboard bench for nem_ohmux_sel_ctrl: default, fast-dwell and 3-input instances.
module tb_nem_ohmux_sel_ctrl;

    localparam int TB_BRK = 4;
    localparam int TB_MK  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       req_valid, req_ready, req_off, sel_valid, busy, done;
    logic [1:0] req_sel, cur_sel;
    logic [3:0] s;

    logic       f_req_valid, f_req_ready, f_req_off, f_sel_valid, f_busy, f_done;
    logic [1:0] f_req_sel, f_cur_sel;
    logic [3:0] f_s;

    logic       t_req_valid, t_req_ready, t_req_off, t_sel_valid, t_busy, t_done;
    logic [1:0] t_req_sel, t_cur_sel;
    logic [2:0] t_s;

    int vectors = 0;
    int errors  = 0;
    logic armed = 1'b0;

    typedef struct {
        int         lat;
        logic [3:0] s;
        logic [1:0] cur;
        logic       sv;
    } exp_t;

    exp_t       q[$];
    logic [1:0] m_cur;
    logic       m_sv;
    logic [3:0] tr_s   [32];
    logic       tr_rdy [32];

    nem_ohmux_sel_ctrl u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_sel(req_sel), .req_off(req_off), .S(s), .cur_sel(cur_sel),
        .sel_valid(sel_valid), .busy(busy), .done(done)
    );

    nem_ohmux_sel_ctrl #(.T_BREAK(1), .T_MAKE(1)) u_fast (
        .clk(clk), .rst(rst), .req_valid(f_req_valid), .req_ready(f_req_ready),
        .req_sel(f_req_sel), .req_off(f_req_off), .S(f_s), .cur_sel(f_cur_sel),
        .sel_valid(f_sel_valid), .busy(f_busy), .done(f_done)
    );

    nem_ohmux_sel_ctrl #(.N_IN(3)) u_n3 (
        .clk(clk), .rst(rst), .req_valid(t_req_valid), .req_ready(t_req_ready),
        .req_sel(t_req_sel), .req_off(t_req_off), .S(t_s), .cur_sel(t_cur_sel),
        .sel_valid(t_sel_valid), .busy(t_busy), .done(t_done)
    );

    // S of every instance must be all-zero or exactly one-hot at all times.
    always @(negedge clk) begin
        if (armed && (!$onehot0(s) || !$onehot0(f_s) || !$onehot0(t_s))) begin
            errors++;
            $display("FAIL onehot0: S=%b f_S=%b t_S=%b (required at most one bit)", s, f_s, t_s);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for done on the default instance, tracing S and req_ready per cycle.
    task automatic wait_done(input int budget, output int lat);
        lat = 0;
        while (1) begin
            if (lat < 32) begin
                tr_s[lat]   = s;
                tr_rdy[lat] = req_ready;
            end
            if (done === 1'b1) break;
            if (lat >= budget) begin
                lat = -1;
                break;
            end
            step();
            lat++;
        end
    endtask

    // Drive one request on the default instance and queue the expected completion.
    task automatic send(input logic [1:0] sel, input logic off);
        exp_t e;
        int   n;
        if (off) begin
            e.lat = TB_BRK; e.s = 4'b0000; e.cur = m_cur; e.sv = 1'b0;
        end else if (sel == m_cur && m_sv) begin
            e.lat = 0; e.s = 4'b0001 << sel; e.cur = m_cur; e.sv = 1'b1;
        end else begin
            e.lat = TB_BRK + TB_MK; e.s = 4'b0001 << sel; e.cur = sel; e.sv = 1'b1;
        end
        m_cur = e.cur;
        m_sv  = e.sv;
        req_sel   = sel;
        req_off   = off;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 64) begin
            step();
            n++;
        end
        if (!req_ready) begin
            vectors++;
            errors++;
            $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
        end
        step();
        req_valid = 1'b0;
        q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b1; req_sel = 2'd1; req_off = 1'b0;
        step(); step();
        rst = 1'b0; req_valid = 1'b0;
        armed = 1'b1;
        vectors++; if (s !== 4'b0000) begin errors++; $display("FAIL reset_S: got %b want 0000", s); end
        vectors++; if (cur_sel !== 2'd0) begin errors++; $display("FAIL reset_cur_sel: got %0d want 0", cur_sel); end
        vectors++; if (sel_valid !== 1'b0) begin errors++; $display("FAIL reset_sel_valid: got %b want 0", sel_valid); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        step();
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_drops_req: busy=%b want 0", busy); end
        m_cur = 2'd0; m_sv = 1'b0;
    endtask

    task automatic test_first_select();
        int lat; exp_t e; logic bad;
        send(2'd2, 1'b0);
        wait_done(40, lat);
        e = q.pop_front();
        vectors++;
        if (lat !== e.lat || s !== e.s || cur_sel !== e.cur || sel_valid !== e.sv) begin
            errors++;
            $display("FAIL first_sel: lat=%0d S=%b cur=%0d sv=%b want lat=%0d S=%b cur=%0d sv=%b",
                     lat, s, cur_sel, sel_valid, e.lat, e.s, e.cur, e.sv);
        end
        bad = 1'b0;
        for (int i = 0; i < TB_BRK; i++) if (tr_s[i] !== 4'b0000) bad = 1'b1;
        if (tr_s[TB_BRK] !== 4'b0100) bad = 1'b1;
        for (int i = 0; i < TB_BRK + TB_MK; i++) if (tr_rdy[i] !== 1'b0) bad = 1'b1;
        vectors++;
        if (bad) begin
            errors++;
            $display("FAIL first_sel_trace: S[0..4]=%b %b %b %b %b want 0000 x4 then 0100, ready low 12 cycles",
                     tr_s[0], tr_s[1], tr_s[2], tr_s[3], tr_s[4]);
        end
    endtask

    task automatic test_noop();
        int lat; exp_t e;
        send(2'd2, 1'b0);
        wait_done(40, lat);
        e = q.pop_front();
        vectors++;
        if (lat !== e.lat || s !== e.s || busy !== 1'b0 || sel_valid !== e.sv) begin
            errors++;
            $display("FAIL noop: lat=%0d S=%b busy=%b sv=%b want lat=%0d S=%b busy=0 sv=%b",
                     lat, s, busy, sel_valid, e.lat, e.s, e.sv);
        end
    endtask

    task automatic test_switch();
        int lat; exp_t e; logic bad;
        send(2'd0, 1'b0);
        wait_done(40, lat);
        e = q.pop_front();
        vectors++;
        if (lat !== e.lat || s !== e.s || cur_sel !== e.cur || sel_valid !== e.sv) begin
            errors++;
            $display("FAIL switch: lat=%0d S=%b cur=%0d sv=%b want lat=%0d S=%b cur=%0d sv=%b",
                     lat, s, cur_sel, sel_valid, e.lat, e.s, e.cur, e.sv);
        end
        bad = 1'b0;
        for (int i = 0; i < TB_BRK; i++) if (tr_s[i] !== 4'b0000) bad = 1'b1;
        for (int i = TB_BRK; i <= TB_BRK + TB_MK; i++) if (tr_s[i] !== 4'b0001) bad = 1'b1;
        vectors++;
        if (bad) begin
            errors++;
            $display("FAIL switch_trace: S[3]=%b S[4]=%b want 0000 then 0001", tr_s[3], tr_s[4]);
        end
    endtask

    task automatic test_back_to_back();
        req_sel = 2'd0; req_off = 1'b0; req_valid = 1'b1;
        step();
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_first: done=%b busy=%b want 1 0", done, busy);
        end
        step();
        req_valid = 1'b0;
        vectors++;
        if (done !== 1'b1) begin errors++; $display("FAIL b2b_second: done=%b want 1", done); end
        step();
        vectors++;
        if (done !== 1'b0) begin errors++; $display("FAIL b2b_pulse_end: done=%b want 0", done); end
    endtask

    task automatic test_off();
        int lat; exp_t e;
        for (int k = 0; k < 2; k++) begin
            send(2'd0, 1'b1);
            wait_done(40, lat);
            e = q.pop_front();
            vectors++;
            if (lat !== e.lat || s !== e.s || cur_sel !== e.cur || sel_valid !== e.sv) begin
                errors++;
                $display("FAIL off_%0d: lat=%0d S=%b cur=%0d sv=%b want lat=%0d S=%b cur=%0d sv=%b",
                         k, lat, s, cur_sel, sel_valid, e.lat, e.s, e.cur, e.sv);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat; exp_t e;
        send(2'd3, 1'b0);
        for (int i = 0; i < 7; i++) step();
        vectors++;
        if (s !== 4'b1000 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_make: S=%b busy=%b want 1000 1", s, busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if (s !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1 || cur_sel !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset: S=%b busy=%b done=%b ready=%b cur=%0d want 0000 0 0 1 0",
                     s, busy, done, req_ready, cur_sel);
        end
        q.delete();
        m_cur = 2'd0; m_sv = 1'b0;
        send(2'd1, 1'b0);
        wait_done(40, lat);
        e = q.pop_front();
        vectors++;
        if (lat !== e.lat || s !== e.s || cur_sel !== e.cur || sel_valid !== e.sv) begin
            errors++;
            $display("FAIL after_reset: lat=%0d S=%b cur=%0d sv=%b want lat=%0d S=%b cur=%0d sv=%b",
                     lat, s, cur_sel, sel_valid, e.lat, e.s, e.cur, e.sv);
        end
    endtask

    task automatic test_hold_busy();
        int n; int lat; exp_t e;
        send(2'd2, 1'b0);
        req_sel = 2'd3; req_off = 1'b0; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 40) begin
            step();
            n++;
        end
        e = q.pop_front();
        vectors++;
        if (n !== e.lat || done !== 1'b1 || s !== e.s || cur_sel !== e.cur) begin
            errors++;
            $display("FAIL hold_first: ready_after=%0d done=%b S=%b cur=%0d want %0d 1 %b %0d",
                     n, done, s, cur_sel, e.lat, e.s, e.cur);
        end
        send(2'd3, 1'b0);
        wait_done(40, lat);
        e = q.pop_front();
        vectors++;
        if (lat !== e.lat || s !== e.s || cur_sel !== e.cur || sel_valid !== e.sv) begin
            errors++;
            $display("FAIL hold_second: lat=%0d S=%b cur=%0d sv=%b want lat=%0d S=%b cur=%0d sv=%b",
                     lat, s, cur_sel, sel_valid, e.lat, e.s, e.cur, e.sv);
        end
    endtask

    task automatic test_fast_dwell();
        int n; logic [3:0] s0; logic [1:0] sel;
        for (int k = 1; k <= 2; k++) begin
            sel = 2'(k);
            f_req_sel = sel; f_req_off = 1'b0; f_req_valid = 1'b1;
            step();
            f_req_valid = 1'b0;
            s0 = f_s;
            n = 0;
            while (f_done !== 1'b1 && n < 20) begin
                step();
                n++;
            end
            vectors++;
            if (n !== 2 || s0 !== 4'b0000 || f_s !== (4'b0001 << sel) || f_cur_sel !== sel || f_sel_valid !== 1'b1) begin
                errors++;
                $display("FAIL fast_%0d: lat=%0d S0=%b S=%b cur=%0d sv=%b want 2 0000 %b %0d 1",
                         k, n, s0, f_s, f_cur_sel, f_sel_valid, 4'b0001 << sel, sel);
            end
        end
    endtask

    task automatic test_n3_oob();
        int n;
        logic [1:0] sels [2];
        int         lats [2];
        logic [2:0] ss   [2];
        logic       svs  [2];
        sels[0] = 2'd2; lats[0] = TB_BRK + TB_MK; ss[0] = 3'b100; svs[0] = 1'b1;
        sels[1] = 2'd3; lats[1] = TB_BRK;         ss[1] = 3'b000; svs[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            t_req_sel = sels[k]; t_req_off = 1'b0; t_req_valid = 1'b1;
            step();
            t_req_valid = 1'b0;
            n = 0;
            while (t_done !== 1'b1 && n < 40) begin
                step();
                n++;
            end
            vectors++;
            if (n !== lats[k] || t_s !== ss[k] || t_cur_sel !== 2'd2 || t_sel_valid !== svs[k]) begin
                errors++;
                $display("FAIL n3_sel%0d: lat=%0d S=%b cur=%0d sv=%b want %0d %b 2 %b",
                         sels[k], n, t_s, t_cur_sel, t_sel_valid, lats[k], ss[k], svs[k]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_sel = 2'd0; req_off = 1'b0;
        f_req_valid = 1'b0; f_req_sel = 2'd0; f_req_off = 1'b0;
        t_req_valid = 1'b0; t_req_sel = 2'd0; t_req_off = 1'b0;
        test_reset();
        test_first_select();
        test_noop();
        test_switch();
        test_back_to_back();
        test_off();
        test_reset_mid();
        test_hold_busy();
        test_fast_dwell();
        test_n3_oob();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
